// File: rtl/winreg_pkg.sv
// Shared types for the windowed register file: window-op encoding and FSM states.
package winreg_pkg;

  typedef enum logic [1:0] {
    WIN_NOP  = 2'b00,
    WIN_PUSH = 2'b01,
    WIN_POP  = 2'b10,
    WIN_RSVD = 2'b11
  } winOp_t;

  typedef enum logic [1:0] {
    IDLE,
    SPILL,
    FILL
  } wrfState_t;

endpackage

// File: rtl/win_addr_map.sv
// Maps a (window, select) pair onto the physical register ring:
// idx = (w*STRIDE + s) mod PHYS.
module win_addr_map #(
  parameter int NREGS   = 8,
  parameter int NWIN    = 4,
  parameter int OVERLAP = 2,
  localparam int STRIDE = NREGS - OVERLAP,
  localparam int PHYS   = NWIN * STRIDE,
  localparam int RSEL   = $clog2(NREGS),
  localparam int CW     = $clog2(NWIN),
  localparam int PW     = $clog2(PHYS)
) (
  input  logic [CW-1:0]   w,
  input  logic [RSEL-1:0] s,
  output logic [PW-1:0]   idx
);

  localparam int SW = $clog2(PHYS + NREGS) + 1;

  logic [SW-1:0] sum;

  // w*STRIDE never exceeds PHYS-STRIDE and s < NREGS, so a single wrap suffices.
  assign sum = SW'(w) * SW'(STRIDE) + SW'(s);
  assign idx = (sum >= SW'(PHYS)) ? PW'(sum - SW'(PHYS)) : PW'(sum);

endmodule

// File: rtl/win_reg_file.sv
// Windowed register file over a physical ring with hardware spill/fill on window overflow/underflow.
// Optional current-window view port enabled by defining WINREG_VIEW_EN.
//
// state | meaning
// IDLE  | normal reads/writes, push/pop handled in one cycle
// SPILL | streaming oldest window's private registers out on the spill port
// FILL  | streaming caller window's private registers in from the fill port
module win_reg_file
  import winreg_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int NWIN    = 4,
  parameter int OVERLAP = 2,
  localparam int STRIDE = NREGS - OVERLAP,
  localparam int PHYS   = NWIN * STRIDE,
  localparam int RSEL   = $clog2(NREGS),
  localparam int CW     = $clog2(NWIN),
  localparam int PW     = $clog2(PHYS)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [RSEL-1:0]  selA,
  input  logic [RSEL-1:0]  selB,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  input  logic [WIDTH-1:0] in,
  input  logic [RSEL-1:0]  selW,
  input  logic             load_L,
  input  logic [1:0]       winAddSub,
  output logic             busy,
  output logic [CW-1:0]    cwp,
  output logic [CW-1:0]    depth,
  output logic [WIDTH-1:0] spillData,
  output logic             spillValid,
  input  logic             spillReady,
  input  logic [WIDTH-1:0] fillData,
  input  logic             fillValid,
  output logic             fillReady
`ifdef WINREG_VIEW_EN
  ,
  output logic [NREGS*WIDTH-1:0] outView
`endif
);

  logic [WIDTH-1:0] regs [PHYS];

  wrfState_t      state, nextState;
  logic [CW-1:0]   cwpNext, depthNext;
  logic [RSEL-1:0] beat, beatNext;
  winOp_t          op;

  logic [PW-1:0]   aIdx, bIdx, wIdx, sfIdx;
  logic [CW-1:0]   sfWin;
  logic            lastBeat;

  assign op = winOp_t'(winAddSub);

  // Spill drains the oldest resident window; fill restores the caller below cwp.
  assign sfWin    = (state == FILL) ? cwp - CW'(1) : cwp - depth;
  assign lastBeat = (beat == RSEL'(STRIDE - 1));

  win_addr_map #(.NREGS(NREGS), .NWIN(NWIN), .OVERLAP(OVERLAP)) u_mapA (
    .w(cwp), .s(selA), .idx(aIdx)
  );

  win_addr_map #(.NREGS(NREGS), .NWIN(NWIN), .OVERLAP(OVERLAP)) u_mapB (
    .w(cwp), .s(selB), .idx(bIdx)
  );

  win_addr_map #(.NREGS(NREGS), .NWIN(NWIN), .OVERLAP(OVERLAP)) u_mapW (
    .w(cwp), .s(selW), .idx(wIdx)
  );

  win_addr_map #(.NREGS(NREGS), .NWIN(NWIN), .OVERLAP(OVERLAP)) u_mapSF (
    .w(sfWin), .s(beat), .idx(sfIdx)
  );

  assign outA       = regs[aIdx];
  assign outB       = regs[bIdx];
  assign busy       = (state != IDLE);
  assign spillValid = (state == SPILL);
  assign fillReady  = (state == FILL);
  // Registers are frozen during SPILL, so the word is stable under back-pressure.
  assign spillData  = (state == SPILL) ? regs[sfIdx] : '0;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < PHYS; i++) regs[i] <= '0;
    end else if (state == IDLE && !load_L) begin
      regs[wIdx] <= in;
    end else if (state == FILL && fillValid) begin
      regs[sfIdx] <= fillData;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      cwp   <= '0;
      depth <= '0;
      beat  <= '0;
    end else begin
      state <= nextState;
      cwp   <= cwpNext;
      depth <= depthNext;
      beat  <= beatNext;
    end
  end

  always_comb begin
    nextState = state;
    cwpNext   = cwp;
    depthNext = depth;
    beatNext  = beat;
    case (state)
      IDLE: begin
        beatNext = '0;
        if (op == WIN_PUSH) begin
          if (depth == CW'(NWIN - 2)) begin
            nextState = SPILL;
          end else begin
            cwpNext   = cwp + CW'(1);
            depthNext = depth + CW'(1);
          end
        end else if (op == WIN_POP) begin
          if (depth == '0) begin
            nextState = FILL;
          end else begin
            cwpNext   = cwp - CW'(1);
            depthNext = depth - CW'(1);
          end
        end
      end
      SPILL: begin
        if (spillReady) begin
          if (lastBeat) begin
            beatNext  = '0;
            cwpNext   = cwp + CW'(1);
            nextState = IDLE;
          end else begin
            beatNext = beat + RSEL'(1);
          end
        end
      end
      FILL: begin
        if (fillValid) begin
          if (lastBeat) begin
            beatNext  = '0;
            cwpNext   = cwp - CW'(1);
            nextState = IDLE;
          end else begin
            beatNext = beat + RSEL'(1);
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

`ifdef WINREG_VIEW_EN
  for (genvar g = 0; g < NREGS; g++) begin : gView
    logic [PW-1:0] viewIdx;

    win_addr_map #(.NREGS(NREGS), .NWIN(NWIN), .OVERLAP(OVERLAP)) u_mapV (
      .w(cwp), .s(RSEL'(g)), .idx(viewIdx)
    );

    assign outView[g*WIDTH +: WIDTH] = regs[viewIdx];
  end
`endif

endmodule

// File: tb/tb_win_reg_file.sv
// Self-checking bench for win_reg_file: directed scenarios plus a randomized run
// against a ring-array/queue reference model.
module tb_win_reg_file;

  localparam int WIDTH   = 16;
  localparam int NREGS   = 8;
  localparam int NWIN    = 4;
  localparam int OVERLAP = 2;
  localparam int STRIDE  = NREGS - OVERLAP;
  localparam int PHYS    = NWIN * STRIDE;

  logic             clock = 1'b0;
  logic             reset_L = 1'b0;
  logic [2:0]       selA = '0, selB = '0, selW = '0;
  logic [WIDTH-1:0] outA, outB;
  logic [WIDTH-1:0] in = '0;
  logic             load_L = 1'b1;
  logic [1:0]       winAddSub = 2'b00;
  logic             busy;
  logic [1:0]       cwp, depth;
  logic [WIDTH-1:0] spillData;
  logic             spillValid;
  logic             spillReady = 1'b0;
  logic [WIDTH-1:0] fillData = '0;
  logic             fillValid = 1'b0;
  logic             fillReady;
`ifdef WINREG_VIEW_EN
  logic [NREGS*WIDTH-1:0] outView;
`endif

  win_reg_file #(.WIDTH(WIDTH), .NREGS(NREGS), .NWIN(NWIN), .OVERLAP(OVERLAP)) dut (
    .clock(clock), .reset_L(reset_L),
    .selA(selA), .selB(selB), .outA(outA), .outB(outB),
    .in(in), .selW(selW), .load_L(load_L), .winAddSub(winAddSub),
    .busy(busy), .cwp(cwp), .depth(depth),
    .spillData(spillData), .spillValid(spillValid), .spillReady(spillReady),
    .fillData(fillData), .fillValid(fillValid), .fillReady(fillReady)
`ifdef WINREG_VIEW_EN
    , .outView(outView)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // reference model: the physical ring plus window bookkeeping
  int mem [PHYS];
  int mCwp, mDepth, mMode;   // mode 0 idle, 1 spilling, 2 filling
  int spillQ[$];
  int fillBeat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int phys(input int w, input int s);
    int wm;
    wm = ((w % NWIN) + NWIN) % NWIN;
    return (wm * STRIDE + s) % PHYS;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < PHYS; i++) mem[i] = 0;
    mCwp = 0; mDepth = 0; mMode = 0; fillBeat = 0;
    spillQ.delete();
  endtask

  task automatic checkResetOutputs();
    chk("rst_outA", outA, 0);
    chk("rst_outB", outB, 0);
    chk("rst_cwp", cwp, 0);
    chk("rst_depth", depth, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spillValid", spillValid, 0);
    chk("rst_fillReady", fillReady, 0);
    chk("rst_spillData", spillData, 0);
  endtask

  task automatic checkOutputs();
    chk("outA", outA, mem[phys(mCwp, selA)]);
    chk("outB", outB, mem[phys(mCwp, selB)]);
    chk("cwp", cwp, mCwp);
    chk("depth", depth, mDepth);
    chk("busy", busy, mMode != 0);
    chk("spillValid", spillValid, mMode == 1);
    chk("fillReady", fillReady, mMode == 2);
    if (mMode == 1) chk("spillData", spillData, spillQ[0]);
  endtask

  task automatic modelEdge();
    case (mMode)
      0: begin
        if (!load_L) mem[phys(mCwp, selW)] = in;
        if (winAddSub == 2'b01) begin
          if (mDepth == NWIN - 2) begin
            mMode = 1;
            for (int b = 0; b < STRIDE; b++) spillQ.push_back(mem[phys(mCwp - mDepth, b)]);
          end else begin
            mCwp = (mCwp + 1) % NWIN;
            mDepth++;
          end
        end else if (winAddSub == 2'b10) begin
          if (mDepth == 0) begin
            mMode = 2;
            fillBeat = 0;
          end else begin
            mCwp = (mCwp + NWIN - 1) % NWIN;
            mDepth--;
          end
        end
      end
      1: begin
        if (spillReady) begin
          void'(spillQ.pop_front());
          if (spillQ.size() == 0) begin
            mMode = 0;
            mCwp = (mCwp + 1) % NWIN;
          end
        end
      end
      default: begin
        if (fillValid) begin
          mem[phys(mCwp - 1, fillBeat)] = int'(fillData);
          fillBeat++;
          if (fillBeat == STRIDE) begin
            mMode = 0;
            mCwp = (mCwp + NWIN - 1) % NWIN;
          end
        end
      end
    endcase
  endtask

  // Inputs are set just after a falling edge; check, then clock the model with the DUT.
  task automatic cycle();
    #1;
    checkOutputs();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
  endtask

  task automatic quiet();
    load_L = 1'b1; winAddSub = 2'b00; spillReady = 1'b0; fillValid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    quiet();
    reset_L = 1'b0;
    modelReset();
    #1;
    checkResetOutputs();
    @(negedge clock);
    reset_L = 1'b1;
  endtask

  task automatic writeReg(input logic [2:0] s, input logic [WIDTH-1:0] d);
    quiet(); load_L = 1'b0; selW = s; in = d;
    cycle();
    quiet();
  endtask

  task automatic windowOp(input logic [1:0] o);
    quiet(); winAddSub = o;
    cycle();
    quiet();
  endtask

  initial begin
    modelReset();
    #2;
    checkResetOutputs();
    @(negedge clock);
    reset_L = 1'b1;

    // write sel6 in window 0, push: it becomes sel0 of window 1
    writeReg(3'd6, 16'h1234);
    windowOp(2'b01);
    selA = 3'd0; selB = 3'd6;
    #1;
    chk("alias_cwp", cwp, 1);
    chk("alias_sel0", outA, 16'h1234);
    chk("alias_sel6", outB, 16'h0000);
    cycle();

    // spill with toggling back-pressure
    doReset();
    for (int i = 0; i < STRIDE; i++) writeReg(3'(i), 16'(16'hA0 + i));
    windowOp(2'b01);
    windowOp(2'b01);
    windowOp(2'b01);
    begin
      int beats = 0;
      int k = 0;
      logic [WIDTH-1:0] held;
      while (busy && k < 40) begin
        spillReady = (k % 2 == 1);
        #1;
        if (spillValid && !spillReady) held = spillData;
        if (spillValid && spillReady) begin
          chk("spill_beat", spillData, 16'(16'hA0 + beats));
          chk("spill_held", spillData, held);
          beats++;
        end
        #0;
        begin
          // undo the #1 so cycle() keeps its own timing
        end
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        k++;
      end
      quiet();
      chk("spill_beats", beats, STRIDE);
      #1;
      chk("spill_busy", busy, 0);
      chk("spill_cwp", cwp, 3);
      chk("spill_depth", depth, 2);
      cycle();
    end

    // underflow fills: from reset pop fills window 3, next pop fills window 2
    doReset();
    windowOp(2'b10);
    for (int k = 0; k < 20 && mMode != 0; k++) begin
      fillValid = 1'b1; fillData = 16'($urandom);
      cycle();
    end
    quiet();
    chk("fill1_cwp", cwp, 3);
    windowOp(2'b10);
    begin
      int b = 0;
      for (int k = 0; k < 30 && mMode != 0; k++) begin
        fillValid = (k % 3 != 2);
        fillData = 16'(16'hB0 + b);
        if (fillValid) b++;
        cycle();
      end
    end
    quiet();
    chk("fill2_cwp", cwp, 2);
    chk("fill2_busy", busy, 0);
    for (int i = 0; i < STRIDE; i++) begin
      selA = 3'(i);
      #1;
      chk("fill_read", outA, 16'(16'hB0 + i));
      cycle();
    end

    // reset in the middle of a spill
    doReset();
    windowOp(2'b01);
    windowOp(2'b01);
    windowOp(2'b01);
    for (int k = 0; k < 3; k++) begin
      spillReady = 1'b1;
      cycle();
    end
    reset_L = 1'b0;
    modelReset();
    #1;
    checkResetOutputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      chk("rst_hold_spillValid", spillValid, 0);
      chk("rst_hold_busy", busy, 0);
    end
    @(negedge clock);
    reset_L = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    quiet();

    // write and push in the same cycle land in the pre-push window
    doReset();
    load_L = 1'b0; selW = 3'd2; in = 16'h5555; winAddSub = 2'b01;
    cycle();
    quiet();
    windowOp(2'b10);
    selA = 3'd2;
    #1;
    chk("wr_push_cwp", cwp, 0);
    chk("wr_push_sel2", outA, 16'h5555);
    cycle();

    // randomized run
    doReset();
    for (int n = 0; n < 2000; n++) begin
      int r;
      selA = 3'($urandom); selB = 3'($urandom); selW = 3'($urandom);
      in = 16'($urandom);
      load_L = ($urandom_range(0, 1) == 0);
      r = $urandom_range(0, 9);
      winAddSub = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      spillReady = ($urandom_range(0, 9) < 7);
      fillValid = ($urandom_range(0, 9) < 7);
      fillData = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
